// File: rtl/instr_fetch_unit.sv
// Instruction fetch sequencer.
// Holds the PC and drives it straight onto the instruction memory address.
// Each fetched {pc, instr} pair goes into a 2-entry FIFO, and decode pops
// the FIFO head.
// A redirect flushes the FIFO and reloads the PC with the target.
//
// Handshake: the head is offered while out_valid is high. It is consumed
// at a rising edge where out_valid and out_ready are both high. Once
// out_valid rises, out_pc/out_instr stay stable until that edge.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
);

  // An unaligned reset PC can never fetch a real instruction, so it is
  // rejected at elaboration.
  if (RESET_PC[1:0] != 2'b00) begin : g_reset_pc_check
    $error("instr_fetch_unit: RESET_PC must be word-aligned");
  end

  logic [31:0] pc_q;
  logic [31:0] fifo_pc    [2];
  logic [31:0] fifo_instr [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  count;
  logic [1:0]  count_next;
  logic        pop;
  logic        fetch;

  // The two low target bits are dropped on purpose: targets are always word addresses.
  logic unused_redirect_bits;
  assign unused_redirect_bits = ^redirect_pc[1:0];

  assign imem_addr = pc_q;
  assign out_valid = (count != 2'd0);
  assign out_pc    = fifo_pc[rd_ptr];
  assign out_instr = fifo_instr[rd_ptr];

  // A pop frees a slot in the same edge, so a full FIFO can still fetch
  // while decode drains it.
  always_comb begin
    pop   = out_valid & out_ready;
    fetch = enable & ~redirect & ((count != 2'd2) | pop);
  end

  // Occupancy after this edge, ignoring redirect, which overrides it.
  always_comb begin
    count_next = count;
    case ({fetch, pop})
      2'b10:   count_next = count + 2'd1;
      2'b01:   count_next = count - 2'd1;
      default: count_next = count;
    endcase
  end

  // PC and FIFO state. A redirect flushes everything. A pop in the same
  // cycle still counts as consumed by decode, so nothing needs replaying.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      fifo_pc[0]    <= 32'h0;
      fifo_pc[1]    <= 32'h0;
      fifo_instr[0] <= 32'h0;
      fifo_instr[1] <= 32'h0;
      rd_ptr        <= 1'b0;
      wr_ptr        <= 1'b0;
      count         <= 2'd0;
    end else if (redirect) begin
      pc_q   <= {redirect_pc[31:2], 2'b00};
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (fetch) begin
        // When full with a pop, wr_ptr equals rd_ptr, so this write
        // replaces the head that is leaving on this same edge.
        fifo_pc[wr_ptr]    <= pc_q;
        fifo_instr[wr_ptr] <= imem_instr;
        wr_ptr             <= ~wr_ptr;
        pc_q               <= pc_q + 32'd4;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count_next;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit.
// The memory model returns 32'hA000_0000 | addr.
// Inputs change on the falling edge and outputs are sampled there.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  int checks = 0;
  int passed = 0;

  // Clock and combinational instruction memory model.
  always #5 clk = ~clk;
  assign imem_instr = 32'hA000_0000 | imem_addr;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .imem_addr   (imem_addr),
    .imem_instr  (imem_instr),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_pc      (out_pc)
  );

  // Advance one rising edge and return at the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Hold reset for two cycles, then release it on a falling edge.
  task automatic do_reset();
    reset       = 1'b1;
    enable      = 1'b0;
    out_ready   = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    enable      = 1'b1;
    out_ready   = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({out_valid, out_pc, out_instr, imem_addr} !== {1'b0, 32'h0, 32'h0, 32'h0})
      $display("FAIL reset_state: valid=%b pc=%h instr=%h addr=%h, expected 0/0/0/0",
               out_valid, out_pc, out_instr, imem_addr);
    else passed++;
    reset = 1'b0;
    checks++;
    if (out_valid !== 1'b0)
      $display("FAIL reset_release_no_valid: valid=%b, expected 0", out_valid);
    else passed++;
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc;
    do_reset();
    enable    = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      exp_pc = 32'(k) * 32'd4;
      checks++;
      if ({out_valid, out_pc, out_instr} !== {1'b1, exp_pc, 32'hA000_0000 | exp_pc})
        $display("FAIL stream_%0d: valid=%b pc=%h instr=%h, expected 1 %h %h",
                 k, out_valid, out_pc, out_instr, exp_pc, 32'hA000_0000 | exp_pc);
      else passed++;
    end
    checks++;
    if (imem_addr !== 32'h10)
      $display("FAIL stream_addr: addr=%h, expected 00000010", imem_addr);
    else passed++;
  endtask

  task automatic test_backpressure();
    do_reset();
    enable    = 1'b1;
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) step();
    checks++;
    if ({out_valid, out_pc, out_instr, imem_addr} !== {1'b1, 32'h0, 32'hA000_0000, 32'h8})
      $display("FAIL bp_full: valid=%b pc=%h instr=%h addr=%h, expected 1 0 A0000000 8",
               out_valid, out_pc, out_instr, imem_addr);
    else passed++;
    out_ready = 1'b1;
    step();
    checks++;
    if ({out_valid, out_pc, out_instr, imem_addr} !== {1'b1, 32'h4, 32'hA000_0004, 32'hC})
      $display("FAIL bp_drain_1: valid=%b pc=%h instr=%h addr=%h, expected 1 4 A0000004 C",
               out_valid, out_pc, out_instr, imem_addr);
    else passed++;
    step();
    checks++;
    if ({out_valid, out_pc, out_instr, imem_addr} !== {1'b1, 32'h8, 32'hA000_0008, 32'h10})
      $display("FAIL bp_drain_2: valid=%b pc=%h instr=%h addr=%h, expected 1 8 A0000008 10",
               out_valid, out_pc, out_instr, imem_addr);
    else passed++;
    step();
    checks++;
    if ({out_valid, out_pc, out_instr} !== {1'b1, 32'hC, 32'hA000_000C})
      $display("FAIL bp_drain_3: valid=%b pc=%h instr=%h, expected 1 C A000000C",
               out_valid, out_pc, out_instr);
    else passed++;
  endtask

  task automatic test_redirect();
    do_reset();
    enable    = 1'b1;
    out_ready = 1'b0;
    step();
    step();
    out_ready = 1'b1;
    step();
    // The FIFO now holds pcs 4 and 8, with 4 at the head.
    checks++;
    if ({out_valid, out_pc, imem_addr} !== {1'b1, 32'h4, 32'hC})
      $display("FAIL redir_setup: valid=%b pc=%h addr=%h, expected 1 4 C",
               out_valid, out_pc, imem_addr);
    else passed++;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0043;
    step();
    checks++;
    if ({out_valid, imem_addr} !== {1'b0, 32'h40})
      $display("FAIL redir_flush: valid=%b addr=%h, expected 0 40", out_valid, imem_addr);
    else passed++;
    redirect = 1'b0;
    step();
    checks++;
    if ({out_valid, out_pc, out_instr} !== {1'b1, 32'h40, 32'hA000_0040})
      $display("FAIL redir_target: valid=%b pc=%h instr=%h, expected 1 40 A0000040",
               out_valid, out_pc, out_instr);
    else passed++;
    step();
    checks++;
    if ({out_valid, out_pc, out_instr} !== {1'b1, 32'h44, 32'hA000_0044})
      $display("FAIL redir_next: valid=%b pc=%h instr=%h, expected 1 44 A0000044",
               out_valid, out_pc, out_instr);
    else passed++;
  endtask

  task automatic test_wrap();
    do_reset();
    enable      = 1'b1;
    out_ready   = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    checks++;
    if ({out_valid, imem_addr} !== {1'b0, 32'hFFFF_FFFC})
      $display("FAIL wrap_load: valid=%b addr=%h, expected 0 FFFFFFFC", out_valid, imem_addr);
    else passed++;
    redirect = 1'b0;
    step();
    // The OR with A0000000 leaves FFFFFFFC unchanged.
    checks++;
    if ({out_valid, out_pc, out_instr, imem_addr} !== {1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0})
      $display("FAIL wrap_top: valid=%b pc=%h instr=%h addr=%h, expected 1 FFFFFFFC FFFFFFFC 0",
               out_valid, out_pc, out_instr, imem_addr);
    else passed++;
    step();
    checks++;
    if ({out_valid, out_pc, out_instr, imem_addr} !== {1'b1, 32'h0, 32'hA000_0000, 32'h4})
      $display("FAIL wrap_zero: valid=%b pc=%h instr=%h addr=%h, expected 1 0 A0000000 4",
               out_valid, out_pc, out_instr, imem_addr);
    else passed++;
  endtask

  task automatic test_enable();
    do_reset();
    enable    = 1'b1;
    out_ready = 1'b0;
    step();
    step();
    enable    = 1'b0;
    out_ready = 1'b1;
    step();
    checks++;
    if ({out_valid, out_pc, imem_addr} !== {1'b1, 32'h4, 32'h8})
      $display("FAIL en_drain_1: valid=%b pc=%h addr=%h, expected 1 4 8",
               out_valid, out_pc, imem_addr);
    else passed++;
    step();
    checks++;
    if ({out_valid, imem_addr} !== {1'b0, 32'h8})
      $display("FAIL en_empty: valid=%b addr=%h, expected 0 8", out_valid, imem_addr);
    else passed++;
    step();
    checks++;
    if ({out_valid, imem_addr} !== {1'b0, 32'h8})
      $display("FAIL en_frozen: valid=%b addr=%h, expected 0 8", out_valid, imem_addr);
    else passed++;
    enable = 1'b1;
    step();
    checks++;
    if ({out_valid, out_pc, out_instr, imem_addr} !== {1'b1, 32'h8, 32'hA000_0008, 32'hC})
      $display("FAIL en_resume: valid=%b pc=%h instr=%h addr=%h, expected 1 8 A0000008 C",
               out_valid, out_pc, out_instr, imem_addr);
    else passed++;
  endtask

  task automatic test_async_reset();
    do_reset();
    enable    = 1'b1;
    out_ready = 1'b0;
    step();
    step();
    checks++;
    if ({out_valid, imem_addr} !== {1'b1, 32'h8})
      $display("FAIL ar_full: valid=%b addr=%h, expected 1 8", out_valid, imem_addr);
    else passed++;
    // Reset pulse lands between edges. Outputs must clear before the next rising edge.
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({out_valid, out_pc, imem_addr} !== {1'b0, 32'h0, 32'h0})
      $display("FAIL ar_immediate: valid=%b pc=%h addr=%h, expected 0 0 0",
               out_valid, out_pc, imem_addr);
    else passed++;
    #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid, out_pc, out_instr, imem_addr} !== {1'b1, 32'h0, 32'hA000_0000, 32'h4})
      $display("FAIL ar_resume: valid=%b pc=%h instr=%h addr=%h, expected 1 0 A0000000 4",
               out_valid, out_pc, out_instr, imem_addr);
    else passed++;
  endtask

  initial begin
    reset       = 1'b1;
    enable      = 1'b0;
    out_ready   = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_enable();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
